// File: rtl/clock_disp_pkg.sv
// ============================================================================
// clock_disp_pkg - digit indices, segment codes and time helpers. Rev 1.0
// ============================================================================
`default_nettype none

package clock_disp_pkg;

   typedef enum logic [1:0] {
      DIG_SEC_U = 2'd0,
      DIG_SEC_T = 2'd1,
      DIG_MIN_U = 2'd2,
      DIG_MIN_T = 2'd3
   } digit_e;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic is_valid_time(input logic [5:0] value);
      return (value <= 6'd59);
   endfunction

endpackage

`default_nettype wire

// File: rtl/clock_display_scan_if.sv
// ============================================================================
// clock_display_scan_if - time inputs and display pin bundle. Rev 1.0
// ============================================================================
`default_nettype none

interface clock_display_scan_if;
   logic [5:0] seconds;
   logic [5:0] minutes;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   logic       dp_n;

   modport master (
      output seconds,
      output minutes,
      input  seg_n,
      input  an_n,
      input  dp_n
   );

   modport slave (
      input  seconds,
      input  minutes,
      output seg_n,
      output an_n,
      output dp_n
   );
endinterface

`default_nettype wire

// File: rtl/clock_seg_decoder.sv
// ============================================================================
// clock_seg_decoder - BCD digit to active-low 7-segment code. Rev 1.0
// ============================================================================
`default_nettype none

module clock_seg_decoder
   import clock_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       dash,
   input  logic       blank,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      if (blank) begin
         seg_n = SEG_BLANK;
      end else if (dash) begin
         seg_n = SEG_DASH;
      end else begin
         case (value)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/clock_display_scan.sv
// ============================================================================
// clock_display_scan - 4-digit multiplexed MM.SS display scanner. Rev 1.0
// ============================================================================
`default_nettype none

module clock_display_scan
   import clock_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   clock_display_scan_if.slave  disp
);

   localparam int unsigned      PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

   logic [PRE_W-1:0] prescaler;
   digit_e           digit;
   logic             init;
   logic [5:0]       snap_sec;
   logic [5:0]       snap_min;
   logic [6:0]       seg_reg;
   logic [3:0]       an_reg;
   logic             dp_reg;

   logic             tick;
   logic [3:0]       value;
   logic             dash;
   logic             blank;
   logic [6:0]       seg_next;
   logic [3:0]       an_next;
   logic             dp_next;

   assign tick = (prescaler == PRE_MAX);

   always_comb begin
      value = 4'd0;
      dash  = 1'b0;
      blank = 1'b0;
      case (digit)
         DIG_SEC_U: begin
            value = 4'(snap_sec % 6'd10);
            dash  = !is_valid_time(snap_sec);
         end
         DIG_SEC_T: begin
            value = 4'(snap_sec / 6'd10);
            dash  = !is_valid_time(snap_sec);
         end
         DIG_MIN_U: begin
            value = 4'(snap_min % 6'd10);
            dash  = !is_valid_time(snap_min);
         end
         DIG_MIN_T: begin
            value = 4'(snap_min / 6'd10);
            dash  = !is_valid_time(snap_min);
            blank = BLANK_LZ && (value == 4'd0);
         end
         default: begin
            value = 4'd0;
         end
      endcase
   end

   clock_seg_decoder u_decoder (
      .value (value),
      .dash  (dash),
      .blank (blank),
      .seg_n (seg_next)
   );

   assign an_next = ~(4'b0001 << digit);
   assign dp_next = !((digit == DIG_MIN_U) && !snap_sec[0]);

   // Prescaler and digit hold during the init load so the first slot is full length
   always_ff @(posedge clk) begin
      if (!reset) begin
         prescaler <= '0;
         digit     <= DIG_SEC_U;
         init      <= 1'b1;
         snap_sec  <= 6'd0;
         snap_min  <= 6'd0;
         seg_reg   <= SEG_BLANK;
         an_reg    <= 4'hF;
         dp_reg    <= 1'b1;
      end else if (init) begin
         init      <= 1'b0;
         snap_sec  <= disp.seconds;
         snap_min  <= disp.minutes;
         seg_reg   <= SEG_BLANK;
         an_reg    <= 4'hF;
         dp_reg    <= 1'b1;
      end else begin
         prescaler <= tick ? '0 : prescaler + PRE_W'(1);
         if (tick) begin
            digit <= digit_e'(digit + 2'd1);
         end
         if (tick && (digit == DIG_MIN_T)) begin
            snap_sec <= disp.seconds;
            snap_min <= disp.minutes;
         end
         seg_reg <= seg_next;
         an_reg  <= an_next;
         dp_reg  <= dp_next;
      end
   end

   assign disp.seg_n = seg_reg;
   assign disp.an_n  = an_reg;
   assign disp.dp_n  = dp_reg;

endmodule

`default_nettype wire

// File: tb/tb_clock_display_scan.sv
// ============================================================================
// tb_clock_display_scan - directed vector bench for clock_display_scan. Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_display_scan;

   typedef struct {
      logic [5:0] sec;
      logic [5:0] min;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   clock_display_scan_if if0 ();
   clock_display_scan_if if1 ();

   clock_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .disp  (if0)
   );

   clock_display_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .disp  (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [3:0] an_a,  input logic [3:0] an_e,
                        input logic [6:0] seg_a, input logic [6:0] seg_e,
                        input logic       dp_a,  input logic       dp_e);
      checks++;
      if (an_a !== an_e || seg_a !== seg_e || dp_a !== dp_e) begin
         errors++;
         $display("FAIL %s: got an_n=%h seg_n=%h dp_n=%b, expected an_n=%h seg_n=%h dp_n=%b",
                  name, an_a, seg_a, dp_a, an_e, seg_e, dp_e);
      end
   endtask

   slot_t      vecs [12];
   slot_t      post [4];
   logic [3:0] blk_an  [4];
   logic [6:0] blk_seg [4];
   logic       blk_dp  [4];

   initial begin
      checks = 0;
      errors = 0;

      // seconds, minutes applied at slot start; expected an_n, seg_n, dp_n for the whole slot
      vecs[0]  = '{6'd34, 6'd12, 4'hE, 7'h19, 1'b1};
      vecs[1]  = '{6'd35, 6'd12, 4'hD, 7'h30, 1'b1};
      vecs[2]  = '{6'd35, 6'd12, 4'hB, 7'h24, 1'b0};
      vecs[3]  = '{6'd35, 6'd12, 4'h7, 7'h79, 1'b1};
      vecs[4]  = '{6'd35, 6'd12, 4'hE, 7'h12, 1'b1};
      vecs[5]  = '{6'd60, 6'd7,  4'hD, 7'h30, 1'b1};
      vecs[6]  = '{6'd60, 6'd7,  4'hB, 7'h24, 1'b1};
      vecs[7]  = '{6'd60, 6'd7,  4'h7, 7'h79, 1'b1};
      vecs[8]  = '{6'd60, 6'd7,  4'hE, 7'h3F, 1'b1};
      vecs[9]  = '{6'd60, 6'd7,  4'hD, 7'h3F, 1'b1};
      vecs[10] = '{6'd60, 6'd7,  4'hB, 7'h78, 1'b0};
      vecs[11] = '{6'd60, 6'd7,  4'h7, 7'h40, 1'b1};

      // Blanking instance shows 05:12 throughout
      blk_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
      blk_seg = '{7'h24, 7'h79, 7'h12, 7'h7F};
      blk_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};

      // After the mid-scan reset the display shows 45:21
      post[0] = '{6'd21, 6'd45, 4'hE, 7'h79, 1'b1};
      post[1] = '{6'd21, 6'd45, 4'hD, 7'h24, 1'b1};
      post[2] = '{6'd21, 6'd45, 4'hB, 7'h12, 1'b1};
      post[3] = '{6'd21, 6'd45, 4'h7, 7'h19, 1'b1};

      reset       = 1'b0;
      if0.seconds = 6'd0;
      if0.minutes = 6'd0;
      if1.seconds = 6'd0;
      if1.minutes = 6'd0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset0", if0.an_n, 4'hF, if0.seg_n, 7'h7F, if0.dp_n, 1'b1);
         check("reset1", if1.an_n, 4'hF, if1.seg_n, 7'h7F, if1.dp_n, 1'b1);
         if0.seconds = 6'(i * 13 + 5);
         if0.minutes = 6'(i * 7 + 3);
         if1.seconds = 6'(i * 11);
         if1.minutes = 6'(i * 9 + 1);
      end

      if0.seconds = 6'd34;
      if0.minutes = 6'd12;
      if1.seconds = 6'd12;
      if1.minutes = 6'd5;
      reset       = 1'b1;

      @(negedge clk);
      check("init0", if0.an_n, 4'hF, if0.seg_n, 7'h7F, if0.dp_n, 1'b1);
      check("init1", if1.an_n, 4'hF, if1.seg_n, 7'h7F, if1.dp_n, 1'b1);

      for (int s = 0; s < 12; s++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
               if0.seconds = vecs[s].sec;
               if0.minutes = vecs[s].min;
            end
            check($sformatf("scan slot%0d cyc%0d", s, c),
                  if0.an_n, vecs[s].an, if0.seg_n, vecs[s].seg, if0.dp_n, vecs[s].dp);
            check($sformatf("blank slot%0d cyc%0d", s, c),
                  if1.an_n, blk_an[s % 4], if1.seg_n, blk_seg[s % 4], if1.dp_n, blk_dp[s % 4]);
         end
      end

      // Reset asserted in the middle of a scan (digit 2 slot)
      repeat (8) @(negedge clk);
      @(negedge clk);
      check("pre-reset digit2", if0.an_n, 4'hB, if0.seg_n, 7'h78, if0.dp_n, 1'b0);
      reset       = 1'b0;
      if0.seconds = 6'd21;
      if0.minutes = 6'd45;
      repeat (2) begin
         @(negedge clk);
         check("midscan reset", if0.an_n, 4'hF, if0.seg_n, 7'h7F, if0.dp_n, 1'b1);
      end
      reset = 1'b1;
      @(negedge clk);
      check("re-init", if0.an_n, 4'hF, if0.seg_n, 7'h7F, if0.dp_n, 1'b1);

      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("restart slot%0d cyc%0d", s, c),
                  if0.an_n, post[s].an, if0.seg_n, post[s].seg, if0.dp_n, post[s].dp);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
